seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It holds a frame of N nibbles and shows one digit at a time, advancing at a fixed prescaled rate. It also provides BCD or hexadecimal glyph mode, per-digit decimal points, leading-zero blanking and tear-free frame updates. It sits between the datapath (counters, FSM state displays) and the board's segment/anode pins, and supersedes the single-digit combinational decoder.

---
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-anode 7-segment driver
// with BCD/hex glyphs, decimal points, zero blanking and tear-free updates.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    BLANK   = 7'b1111111;

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic                      tc;
  logic                      wrap;
  logic                      wrap_q;

  logic [4*NUM_DIGITS-1:0]   shd_data;
  logic [NUM_DIGITS-1:0]     shd_dp;
  logic                      shd_lz;
  logic [4*NUM_DIGITS-1:0]   disp_data;
  logic [NUM_DIGITS-1:0]     disp_dp;
  logic                      disp_lz;

  logic [NUM_DIGITS-1:0]     blank;
  logic                      zrun;
  logic [3:0]                nib;
  logic [6:0]                seg_nx;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = (HEX_MODE != 0) ? 7'b0001000 : BLANK;
      4'hB: g = (HEX_MODE != 0) ? 7'b1100000 : BLANK;
      4'hC: g = (HEX_MODE != 0) ? 7'b0110001 : BLANK;
      4'hD: g = (HEX_MODE != 0) ? 7'b1000010 : BLANK;
      4'hE: g = (HEX_MODE != 0) ? 7'b0110000 : BLANK;
      default: g = (HEX_MODE != 0) ? 7'b0111000 : BLANK;
    endcase
    return g;
  endfunction

  assign tc   = (cnt == CNT_MAX);
  assign wrap = tc && (idx == IDX_MAX);

  // Prescaler and digit index; index steps once per SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tc) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow capture and frame-boundary transfer into the display copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data  <= '0;
      shd_dp    <= '0;
      shd_lz    <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_lz   <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (wrap && pending) begin
        disp_data <= shd_data;
        disp_dp   <= shd_dp;
        disp_lz   <= shd_lz;
      end
      if (load) begin
        shd_data <= data;
        shd_dp   <= dp_in;
        shd_lz   <= lz_en;
        pending  <= 1'b1;
      end else if (wrap) begin
        pending  <= 1'b0;
      end
    end
  end

  // Blank zero digits from the top down until the first nonzero one.
  always_comb begin
    blank = '0;
    zrun  = disp_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zrun     = zrun && (disp_data[4*i +: 4] == 4'd0);
      blank[i] = zrun;
    end
  end

  // Segment pattern for the digit currently selected.
  always_comb begin
    nib    = disp_data[{idx, 2'b00} +: 4];
    seg_nx = blank[idx] ? BLANK : glyph(nib);
  end

  // Registered pin outputs; all change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= BLANK;
      dp         <= 1'b1;
      an         <= '1;
      wrap_q     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nx;
      dp         <= ~disp_dp[idx];
      an         <= ~(NUM_DIGITS'(1) << idx);
      wrap_q     <= wrap;
      frame_tick <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench, BCD and hex instances side by side
// against a cycle-count frame model.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FR = N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;

  logic [6:0] seg_b, seg_h;
  logic       dp_b, dp_h;
  logic [3:0] an_b, an_h;
  logic       pend_b, pend_h;
  logic       ft_b, ft_h;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_MODE(0)) u_bcd (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .dp_in(dp_in), .lz_en(lz_en), .seg(seg_b), .dp(dp_b),
    .an(an_b), .pending(pend_b), .frame_tick(ft_b)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .dp_in(dp_in), .lz_en(lz_en), .seg(seg_h), .dp(dp_h),
    .an(an_h), .pending(pend_h), .frame_tick(ft_h)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] sb;
    logic [6:0] sh;
    logic       dp;
    logic [3:0] an;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  logic [6:0] gl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          k = 0;
  logic [15:0] sh_d = '0, ds_d = '0;
  logic [3:0]  sh_dp = '0, ds_dp = '0;
  logic        sh_lz = 1'b0, ds_lz = 1'b0, pend = 1'b0;

  function automatic logic [6:0] exp_seg(input logic [15:0] d,
                                         input logic lz,
                                         input int i,
                                         input bit hex);
    logic [3:0] v;
    v = d[4*i +: 4];
    if (lz && i > 0 && (d >> (4*i)) == 16'd0) return 7'h7f;
    if (!hex && v > 4'd9) return 7'h7f;
    return gl[v];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s t=%0t k=%0d got=%h want=%h",
               nm, $time, k, act, want);
    end
  endtask

  // Reference model: digit position and frame boundaries from cycle count.
  initial begin
    exp_t e;
    int i;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0;
        sh_d = '0; sh_dp = '0; sh_lz = 1'b0;
        ds_d = '0; ds_dp = '0; ds_lz = 1'b0;
        pend = 1'b0;
        q.delete();
        e = '{7'h7f, 7'h7f, 1'b1, 4'hf, 1'b0, 1'b0};
        q.push_back(e);
      end else begin
        k++;
        i = ((k - 1) / SD) % N;
        e.sb = exp_seg(ds_d, ds_lz, i, 1'b0);
        e.sh = exp_seg(ds_d, ds_lz, i, 1'b1);
        e.dp = ~ds_dp[i];
        e.an = ~(4'b0001 << i);
        e.ft = (k > FR) && ((k - 1) % FR == 0);
        if (k % FR == 0 && pend) begin
          ds_d = sh_d; ds_dp = sh_dp; ds_lz = sh_lz;
          pend = 1'b0;
        end
        if (load) begin
          sh_d = data; sh_dp = dp_in; sh_lz = lz_en;
          pend = 1'b1;
        end
        e.pend = pend;
        q.push_back(e);
      end
    end
  end

  // Monitor: pop one expectation per cycle, compare both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seg_bcd", 32'(seg_b), 32'(e.sb));
        chk("seg_hex", 32'(seg_h), 32'(e.sh));
        chk("dp",      32'(dp_b),  32'(e.dp));
        chk("dp_hex",  32'(dp_h),  32'(e.dp));
        chk("an",      32'(an_b),  32'(e.an));
        chk("an_hex",  32'(an_h),  32'(e.an));
        chk("pending", 32'(pend_b), 32'(e.pend));
        chk("pend_hex", 32'(pend_h), 32'(e.pend));
        chk("frame_tick", 32'(ft_b), 32'(e.ft));
        chk("ft_hex",  32'(ft_h),  32'(e.ft));
      end else begin
        chk("no_expectation", 32'(q.size()), 32'd1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                         input logic l);
    data = d; dp_in = p; lz_en = l; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int j = 0; j < 4 * FR; j++) begin
      if (k % FR == ph) return;
      cyc(1);
    end
    chk("phase_timeout", 32'(k % FR), 32'(ph));
  endtask

  initial begin
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    wait_phase(5);
    do_load(16'h1234, 4'b0000, 1'b0);
    cyc(40);
    wait_phase(3);
    do_load(16'hFA0C, 4'b0101, 1'b0);
    cyc(40);
    wait_phase(7);
    do_load(16'h0050, 4'b1000, 1'b1);
    cyc(40);
    wait_phase(9);
    do_load(16'h0000, 4'b0000, 1'b1);
    cyc(40);
    wait_phase(2);
    do_load(16'h1111, 4'b0000, 1'b0);
    cyc(3);
    do_load(16'h2222, 4'b0000, 1'b0);
    cyc(40);
    wait_phase(3);
    do_load(16'h4321, 4'b0010, 1'b0);
    wait_phase(FR - 1);
    do_load(16'h8765, 4'b0100, 1'b0);
    cyc(50);
    wait_phase(6);
    do_load(16'h9999, 4'b1111, 1'b0);
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(40);
    repeat (400) begin
      if ($urandom_range(0, 9) == 0)
        do_load(16'($urandom), 4'($urandom), 1'($urandom));
      else
        cyc(1);
    end
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
